decodificador_bcd_ss_t: RTL and testbench

DECODIFICADOR_BCD_SS_T -- requirements
Module: decodificador_bcd_ss_t

---
 rtl/decodificador_bcd_ss_t_if.sv | 28 ++
 rtl/decodificador_bcd_ss_t.sv | 105 ++++++++++
 tb/tb_decodificador_bcd_ss_t.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/decodificador_bcd_ss_t_if.sv
// Request/response bundle for the BCD-to-binary converter: start/data in, result and status flags out.
// No backpressure: start is sampled only when the converter is idle, and outputs are single-cycle pulses.
interface decodificador_bcd_ss_t_if;
  logic       start;
  logic [7:0] data_bcd;
  logic [5:0] bin_out;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (
    output start,
    output data_bcd,
    input  bin_out,
    input  valid,
    input  error,
    input  busy
  );

  modport slave (
    input  start,
    input  data_bcd,
    output bin_out,
    output valid,
    output error,
    output busy
  );
endinterface

// File: rtl/decodificador_bcd_ss_t.sv
// Two-digit packed BCD to 6-bit binary by repeated add-10; valid at E0+tens+2, error at E0+2.
// No backpressure: start is ignored while busy, and results are one-cycle Moore pulses.
module decodificador_bcd_ss_t #(
  parameter int unsigned MAX_TENS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  decodificador_bcd_ss_t_if.slave bus
);

  localparam logic [3:0] MaxTens = 4'(MAX_TENS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CONV  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [5:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] bin_q, bin_d;
  logic       rej_q, rej_d;
  logic       illegal;

  assign illegal = (tens_q > MaxTens) || (units_q > 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tens_q  <= '0;
      units_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    rej_d   = rej_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tens_d  = bus.data_bcd[7:4];
          units_d = bus.data_bcd[3:0];
          rej_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A rejected code spends a second cycle here so error lands at E0+2,
        // the same point a tens=0 conversion reports valid.
        if (rej_q) begin
          state_d = ERR;
        end else if (illegal) begin
          rej_d = 1'b1;
        end else begin
          acc_d   = {2'b00, units_q};
          cnt_d   = tens_q;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q != 4'd0) begin
          acc_d = acc_q + 6'd10;
          cnt_d = cnt_q - 4'd1;
        end else begin
          bin_d   = acc_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        rej_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bin_out = bin_q;
  assign bus.valid   = (state_q == DONE);
  assign bus.error   = (state_q == ERR);
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_decodificador_bcd_ss_t.sv
// Directed bench for the BCD converter; a scoreboard queue holds the expected pulse kind, value and cycle.
module tb_decodificador_bcd_ss_t;

  typedef struct {
    logic       is_err;
    logic [5:0] val;
    int         due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  logic [5:0] last_bin;
  exp_t sb[$];

  decodificador_bcd_ss_t_if ifc ();

  decodificador_bcd_ss_t #(.MAX_TENS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [7:0] d);
    return (d[7:4] <= 4'd5) && (d[3:0] <= 4'd9);
  endfunction

  function automatic logic [5:0] to_bin(input logic [7:0] d);
    int v;
    v = int'(d[7:4]) * 10 + int'(d[3:0]);
    return 6'(v);
  endfunction

  // Push the expectation for a start issued at the upcoming edge (E0).
  task automatic push_exp(input logic [7:0] d);
    exp_t e;
    e.is_err = !is_legal(d);
    e.val    = to_bin(d);
    e.due    = cyc + 1 + (e.is_err ? 2 : int'(d[7:4]) + 2);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    while (ifc.busy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk(tag, {31'd0, ifc.busy}, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] d);
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.data_bcd = d;
    push_exp(d);
    @(negedge clk);
    ifc.start    = 1'b0;
    ifc.data_bcd = 8'($urandom);
    chk("busy_after_e0", {31'd0, ifc.busy}, 32'd1);
    wait_idle("idle_timeout");
    chk("bin_hold_idle", {26'd0, ifc.bin_out}, {26'd0, last_bin});
  endtask

  // Pulse monitor: every valid/error must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ifc.valid || ifc.error)) begin
      chk("excl_pulse", {31'd0, ifc.valid & ifc.error}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, ifc.valid, ifc.error}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, ifc.error}, {31'd0, e.is_err});
        chk("pulse_cycle", cyc, e.due);
        if (e.is_err) begin
          chk("bin_hold_err", {26'd0, ifc.bin_out}, {26'd0, last_bin});
        end else begin
          chk("bin_value", {26'd0, ifc.bin_out}, {26'd0, e.val});
          last_bin = e.val;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total        = 0;
    bad          = 0;
    last_bin     = 6'd0;
    reset        = 1'b1;
    ifc.start    = 1'b0;
    ifc.data_bcd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_bin", {26'd0, ifc.bin_out}, 32'd0);
    chk("rst_valid", {31'd0, ifc.valid}, 32'd0);
    chk("rst_error", {31'd0, ifc.error}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    reset = 1'b0;

    // Longest legal conversion, then the shortest ones.
    do_start(8'h59);
    do_start(8'h00);
    do_start(8'h07);

    // Rejected codes leave bin_out untouched.
    do_start(8'h60);
    do_start(8'h3A);

    // start held through every busy cycle must not queue a second request.
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.data_bcd = 8'h42;
    push_exp(8'h42);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ifc.busy) break;
      ifc.start    = 1'b1;
      ifc.data_bcd = 8'h11;
    end
    ifc.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignored_starts_bin", {26'd0, ifc.bin_out}, 32'd42);
    chk("ignored_starts_sb", sb.size(), 32'd0);

    // Reset in the middle of CONV aborts without a pulse.
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.data_bcd = 8'h55;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'd0, ifc.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_bin", {26'd0, ifc.bin_out}, 32'd0);
    chk("abort_valid", {31'd0, ifc.valid}, 32'd0);
    chk("abort_error", {31'd0, ifc.error}, 32'd0);
    chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
    last_bin = 6'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_start(8'h12);

    // Full code sweep.
    for (int c = 0; c < 256; c++) begin
      do_start(8'(c));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
